// File: rtl/uart_result_tx.sv
// Result framer for the UART TX core.
// Sends header, result and XOR checksum per result, with one pending slot.
module uart_result_tx #(
    parameter int                    NB_DATA  = 8,
    parameter int                    NB_OP    = 6,
    parameter logic [NB_OP-1:0]      TYPE_RES = 6'b000100,
    parameter int                    NB_CNT   = 8
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_overflow,
    output logic [NB_CNT-1:0]  o_frames
);

    localparam logic [NB_DATA-1:0] HDR =
        {{(NB_DATA-NB_OP){1'b0}}, TYPE_RES};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT
    } state_e;

    state_e             state_q;
    logic [1:0]         idx_q;
    logic [NB_DATA-1:0] active_q;
    logic [NB_DATA-1:0] pend_q;
    logic               pend_vld_q;
    logic [NB_DATA-1:0] tx_data_q;
    logic               tx_start_q;
    logic               busy_q;
    logic               ovf_q;
    logic [NB_CNT-1:0]  frames_q;

    logic [1:0]         idx_d;
    logic [NB_CNT-1:0]  frames_d;
    logic               last_done;
    logic               in_frame;

    function automatic logic [NB_DATA-1:0] frame_byte(
        input logic [1:0]         idx,
        input logic [NB_DATA-1:0] res
    );
        logic [NB_DATA-1:0] b;
        unique case (idx)
            2'd0:    b = HDR;
            2'd1:    b = res;
            default: b = HDR ^ res;
        endcase
        return b;
    endfunction

    assign idx_d     = idx_q + 2'd1;
    assign frames_d  = frames_q + NB_CNT'(1);
    assign in_frame  = (state_q != S_IDLE);
    assign last_done = (state_q == S_WAIT) && i_tx_done && (idx_q == 2'd2);

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= 2'd0;
            active_q   <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            frames_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (i_valid) begin
                        active_q   <= i_result;
                        idx_q      <= 2'd0;
                        tx_data_q  <= HDR;
                        tx_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_SEND;
                    end
                end
                S_SEND: begin
                    tx_start_q <= 1'b0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_tx_done && idx_q != 2'd2) begin
                        idx_q      <= idx_d;
                        tx_data_q  <= frame_byte(idx_d, active_q);
                        tx_start_q <= 1'b1;
                        state_q    <= S_SEND;
                    end else if (last_done) begin
                        frames_q <= frames_d;
                        idx_q    <= 2'd0;
                        if (pend_vld_q) begin
                            // Pending drains while a same-cycle result refills it
                            active_q   <= pend_q;
                            pend_vld_q <= i_valid;
                            if (i_valid) begin
                                pend_q <= i_result;
                            end
                            tx_data_q  <= HDR;
                            tx_start_q <= 1'b1;
                            state_q    <= S_SEND;
                        end else if (i_valid) begin
                            active_q   <= i_result;
                            tx_data_q  <= HDR;
                            tx_start_q <= 1'b1;
                            state_q    <= S_SEND;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    tx_start_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase

            if (in_frame && !last_done && i_valid) begin
                if (!pend_vld_q) begin
                    pend_q     <= i_result;
                    pend_vld_q <= 1'b1;
                end else begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = busy_q;
    assign o_overflow = ovf_q;
    assign o_frames   = frames_q;

endmodule

// File: tb/tb_uart_result_tx.sv
// Bench for uart_result_tx: fixed frame vectors, corner sequences
// and random traffic against a two-slot queue model of the framer.
module tb_uart_result_tx;

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic       i_valid;
    logic [7:0] i_result;
    logic       i_tx_done;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_busy;
    logic       o_overflow;
    logic [7:0] o_frames;

    uart_result_tx dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .i_result   (i_result),
        .i_tx_done  (i_tx_done),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .o_busy     (o_busy),
        .o_overflow (o_overflow),
        .o_frames   (o_frames)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;

    logic [7:0] got[$];
    logic [7:0] expq[$];
    int         outst;
    int         ndone;
    bit         byte_out;
    bit         ovf_m;
    logic [7:0] frames_m;
    logic [7:0] last_b;
    bit         armed;
    int         cnt;
    int         dly;
    bit         rand_dly;

    typedef struct {
        logic [7:0] res;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void model_reset();
        outst    = 0;
        ndone    = 0;
        byte_out = 0;
        ovf_m    = 0;
        frames_m = 8'd0;
        armed    = 0;
        expq.delete();
    endfunction

    // Applies the current inputs at one edge, then models the TX core
    // and compares the DUT with the queue model.
    task automatic tick();
        bit fin;
        fin = 0;
        if (!i_rst_n) begin
            model_reset();
        end else begin
            fin = i_tx_done && byte_out && (ndone % 3 == 2);
            if (i_tx_done && byte_out) begin
                ndone++;
                byte_out = 0;
            end
            if (fin) begin
                outst--;
                frames_m++;
            end
            if (i_valid) begin
                if (outst < 2) begin
                    outst++;
                    expq.push_back(8'h04);
                    expq.push_back(i_result);
                    expq.push_back(8'h04 ^ i_result);
                end else begin
                    ovf_m = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        i_valid   = 1'b0;
        i_tx_done = 1'b0;
        if (armed) begin
            cnt--;
            if (cnt == 0) begin
                i_tx_done = 1'b1;
                armed     = 0;
            end
        end
        if (o_tx_start) begin
            got.push_back(o_tx_data);
            if (expq.size() == 0)
                chk("start_unexpected", int'(o_tx_start), 0);
            else
                chk("tx_byte", int'(o_tx_data), int'(expq.pop_front()));
            byte_out = 1;
            last_b   = o_tx_data;
            armed    = 1;
            cnt      = rand_dly ? int'($urandom_range(1, 6)) : dly;
        end else if (byte_out) begin
            chk("data_hold", int'(o_tx_data), int'(last_b));
        end
        chk("busy", int'(o_busy), int'(outst > 0));
        chk("overflow", int'(o_overflow), int'(ovf_m));
        chk("frames", int'(o_frames), int'(frames_m));
    endtask

    task automatic send(input logic [7:0] r);
        i_valid  = 1'b1;
        i_result = r;
        tick();
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (o_busy && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", int'(o_busy), 0);
    endtask

    task automatic wait_final(input int k);
        int n;
        n = 0;
        while (!(i_tx_done && got.size() == k) && n < 300) begin
            tick();
            n++;
        end
        chk("sync_timeout", int'(i_tx_done), 1);
    endtask

    task automatic cmp_bytes(input string nm, input logic [7:0] e[$]);
        chk({nm, "_len"}, got.size(), e.size());
        for (int i = 0; i < e.size(); i++) begin
            if (i < got.size())
                chk(nm, int'(got[i]), int'(e[i]));
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] f0;
        vt[0] = '{8'h2A, 8'h04, 8'h2A, 8'h2E};
        vt[1] = '{8'hF3, 8'h04, 8'hF3, 8'hF7};
        vt[2] = '{8'h00, 8'h04, 8'h00, 8'h04};
        vt[3] = '{8'hFF, 8'h04, 8'hFF, 8'hFB};
        vt[4] = '{8'h80, 8'h04, 8'h80, 8'h84};
        vt[5] = '{8'h04, 8'h04, 8'h04, 8'h00};

        i_rst_n   = 1'b0;
        i_valid   = 1'b0;
        i_result  = 8'h00;
        i_tx_done = 1'b0;
        rand_dly  = 0;
        dly       = 10;
        model_reset();
        tick();
        tick();
        chk("rst_data", int'(o_tx_data), 0);
        chk("rst_start", int'(o_tx_start), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_ovf", int'(o_overflow), 0);
        chk("rst_frames", int'(o_frames), 0);
        i_rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            got.delete();
            f0 = o_frames;
            send(vt[i].res);
            chk("first_start", int'(o_tx_start), 1);
            wait_idle(200);
            cmp_bytes("vec", '{vt[i].b0, vt[i].b1, vt[i].b2});
            chk("vec_frames", int'(o_frames), int'(f0 + 8'd1));
        end

        got.delete();
        f0 = o_frames;
        send(8'h11);
        send(8'h22);
        wait_final(3);
        tick();
        chk("b2b_gap", int'(o_tx_start), 1);
        chk("b2b_hdr", int'(o_tx_data), 8'h04);
        wait_idle(300);
        cmp_bytes("b2b", '{8'h04, 8'h11, 8'h15, 8'h04, 8'h22, 8'h26});
        chk("b2b_ovf", int'(o_overflow), 0);
        chk("b2b_frames", int'(o_frames), int'(f0 + 8'd2));

        got.delete();
        send(8'h01);
        send(8'h02);
        send(8'h03);
        chk("ovf_set", int'(o_overflow), 1);
        wait_idle(300);
        cmp_bytes("ovf", '{8'h04, 8'h01, 8'h05, 8'h04, 8'h02, 8'h06});
        chk("ovf_sticky", int'(o_overflow), 1);

        do_reset();
        got.delete();
        send(8'h10);
        send(8'h20);
        wait_final(3);
        i_valid  = 1'b1;
        i_result = 8'h30;
        tick();
        chk("refill_no_ovf", int'(o_overflow), 0);
        wait_idle(400);
        cmp_bytes("refill", '{8'h04, 8'h10, 8'h14, 8'h04, 8'h20, 8'h24,
                              8'h04, 8'h30, 8'h34});
        chk("refill_ovf_end", int'(o_overflow), 0);

        got.delete();
        send(8'h77);
        for (int n = 0; n < 100 && got.size() < 2; n++) tick();
        chk("mid_sync", got.size(), 2);
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        chk("mid_data", int'(o_tx_data), 0);
        chk("mid_start", int'(o_tx_start), 0);
        chk("mid_busy", int'(o_busy), 0);
        chk("mid_frames", int'(o_frames), 0);
        i_tx_done = 1'b1;
        tick();
        chk("stray_start", int'(o_tx_start), 0);
        chk("stray_busy", int'(o_busy), 0);
        for (int n = 0; n < 15; n++) tick();
        got.delete();
        send(8'h55);
        wait_idle(200);
        cmp_bytes("post_rst", '{8'h04, 8'h55, 8'h51});

        do_reset();
        dly = 1;
        for (int i = 0; i < 256; i++) begin
            send(8'(i));
            wait_idle(50);
        end
        chk("wrap", int'(o_frames), 0);

        do_reset();
        rand_dly = 1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                i_valid  = 1'b1;
                i_result = 8'($urandom);
            end
            tick();
        end
        wait_idle(500);
        chk("drain", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
